// File: rtl/perceptron_pkg.sv
// -----------------------------------------------------------------------------
// perceptron_pkg
//   Shared definitions for the perceptron accumulator and the upstream
//   12-operand 3-bit Wallace compressor wrapper.
//   Contents:
//     state_t            accumulator FSM states {IDLE, ACCUM, DONE}
//     WALLACE_SUM_W      width of one compressed sum beat (7 bits)
//     WALLACE_SUM_MAX    largest legal compressed sum (12 * 7 = 84)
//     DEFAULT_*          default accumulator sizing shared across the slice
// -----------------------------------------------------------------------------
package perceptron_pkg;

    localparam int unsigned WALLACE_SUM_W   = 7;
    localparam int unsigned WALLACE_SUM_MAX = 84;

    localparam int unsigned DEFAULT_ACC_W     = 12;
    localparam int unsigned DEFAULT_MAX_BEATS = 32;
    localparam int unsigned DEFAULT_CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/perceptron_acc_add.sv
// -----------------------------------------------------------------------------
// perceptron_acc_add
//   Combinational accumulator adder: o_sum = i_acc + zero-extended i_addend.
//   Optional feature macro: PERCEPTRON_ACC_SAT_EN
//     defined   : ACC_W+1 bit add; on carry-out the sum clamps to all-ones and
//                 o_ovf is raised.
//     undefined : plain modulo-2^ACC_W add; o_ovf is constant 0.
//   Ports:
//     i_acc     [ACC_W-1:0]          current accumulator value
//     i_addend  [WALLACE_SUM_W-1:0]  compressed sum beat
//     o_sum     [ACC_W-1:0]          next accumulator value
//     o_ovf                          saturation occurred on this add
// -----------------------------------------------------------------------------
module perceptron_acc_add
    import perceptron_pkg::*;
#(
    parameter int unsigned ACC_W = DEFAULT_ACC_W
) (
    input  logic [ACC_W-1:0]         i_acc,
    input  logic [WALLACE_SUM_W-1:0] i_addend,
    output logic [ACC_W-1:0]         o_sum,
    output logic                     o_ovf
);

`ifdef PERCEPTRON_ACC_SAT_EN
    logic [ACC_W:0] w_wide;

    assign w_wide = {1'b0, i_acc} + {{(ACC_W + 1 - WALLACE_SUM_W){1'b0}}, i_addend};
    assign o_sum  = w_wide[ACC_W] ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];
    assign o_ovf  = w_wide[ACC_W];
`else
    assign o_sum = i_acc + {{(ACC_W - WALLACE_SUM_W){1'b0}}, i_addend};
    assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/perceptron_accum.sv
// -----------------------------------------------------------------------------
// perceptron_accum
//   Accumulates the compressed-sum beats of one input vector and compares the
//   total against a threshold sampled on the vector's first beat. The result
//   is presented on a valid/ready output port and held until accepted.
//   Optional feature macro: PERCEPTRON_ACC_SAT_EN (saturating accumulator,
//   handled entirely inside perceptron_acc_add).
//   Ports:
//     clk, reset          single clock; synchronous active-high reset
//     in_valid/in_ready   input beat handshake (in_ready = state != DONE)
//     sum_in              7-bit compressed sum beat
//     in_last             final beat of the current vector
//     threshold           firing threshold, sampled on the first beat
//     out_valid/out_ready result handshake
//     out_sum             accumulated total
//     out_fire            out_sum >= sampled threshold (unsigned)
//     out_beats           beats accepted in the vector
//     out_err             vector force-terminated at MAX_BEATS
//     out_ovf             accumulator saturated during the vector
// -----------------------------------------------------------------------------
module perceptron_accum
    import perceptron_pkg::*;
#(
    parameter int unsigned ACC_W     = DEFAULT_ACC_W,
    parameter int unsigned MAX_BEATS = DEFAULT_MAX_BEATS,
    parameter int unsigned CNT_W     = DEFAULT_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WALLACE_SUM_W-1:0] sum_in,
    input  logic                     in_last,
    input  logic [ACC_W-1:0]         threshold,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_sum,
    output logic                     out_fire,
    output logic [CNT_W-1:0]         out_beats,
    output logic                     out_err,
    output logic                     out_ovf
);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_thr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic               r_ovf;
    logic               r_fire;

    logic               w_beat;
    logic [ACC_W-1:0]   w_add_a;
    logic [ACC_W-1:0]   w_sum;
    logic               w_ovf;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [ACC_W-1:0]   w_thr_eff;
    logic               w_fire;
    logic               w_hit_max;

    assign in_ready = (r_state != DONE);
    assign w_beat   = in_valid && in_ready;

    // The first beat of a vector starts from zero rather than the stale total.
    assign w_add_a   = (r_state == IDLE) ? '0 : r_acc;
    // In IDLE the threshold register has not been loaded yet, so compare
    // against the live input for single-beat vectors.
    assign w_thr_eff = (r_state == IDLE) ? threshold : r_thr;
    assign w_fire    = (w_sum >= w_thr_eff);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_hit_max = (w_cnt_inc == CNT_W'(MAX_BEATS));

    perceptron_acc_add #(
        .ACC_W (ACC_W)
    ) u_acc_add (
        .i_acc    (w_add_a),
        .i_addend (sum_in),
        .o_sum    (w_sum),
        .o_ovf    (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_thr   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_fire  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_beat) begin
                        r_acc <= w_sum;
                        r_thr <= threshold;
                        r_cnt <= CNT_W'(1);
                        r_err <= 1'b0;
                        r_ovf <= w_ovf;
                        if (in_last) begin
                            r_fire  <= w_fire;
                            r_state <= DONE;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (w_beat) begin
                        r_acc <= w_sum;
                        r_cnt <= w_cnt_inc;
                        // Overflow stays sticky for the rest of the vector.
                        r_ovf <= r_ovf | w_ovf;
                        if (in_last) begin
                            r_fire  <= w_fire;
                            r_state <= DONE;
                        end else if (w_hit_max) begin
                            r_fire  <= w_fire;
                            r_err   <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_fire  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == DONE);
    assign out_sum   = r_acc;
    assign out_fire  = r_fire;
    assign out_beats = r_cnt;
    assign out_err   = r_err;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_perceptron_accum.sv
// -----------------------------------------------------------------------------
// tb_perceptron_accum
//   Drives two instances in lockstep (ACC_W=12 and ACC_W=8) with shared
//   inputs; both are compared against a sum-of-beats reference model that
//   wraps or saturates according to PERCEPTRON_ACC_SAT_EN.
// -----------------------------------------------------------------------------
module tb_perceptron_accum;
    import perceptron_pkg::*;

    localparam int unsigned ACC_W     = 12;
    localparam int unsigned ACC_W8    = 8;
    localparam int unsigned MAX_BEATS = 32;
    localparam int unsigned CNT_W     = 6;
    localparam int          BOUND     = 200;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_last;
    logic             out_ready;
    logic [6:0]       sum_in;
    logic [ACC_W-1:0] threshold;

    logic             in_ready, out_valid, out_fire, out_err, out_ovf;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_beats;

    logic              in_ready8, out_valid8, out_fire8, out_err8, out_ovf8;
    logic [ACC_W8-1:0] out_sum8;
    logic [CNT_W-1:0]  out_beats8;

    int n_checks = 0;
    int n_pass   = 0;
    int beats[$];

    always #5 clk = ~clk;

    perceptron_accum #(
        .ACC_W     (ACC_W),
        .MAX_BEATS (MAX_BEATS),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .in_last   (in_last),
        .threshold (threshold),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_fire  (out_fire),
        .out_beats (out_beats),
        .out_err   (out_err),
        .out_ovf   (out_ovf)
    );

    perceptron_accum #(
        .ACC_W     (ACC_W8),
        .MAX_BEATS (MAX_BEATS),
        .CNT_W     (CNT_W)
    ) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .sum_in    (sum_in),
        .in_last   (in_last),
        .threshold (threshold[ACC_W8-1:0]),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_sum   (out_sum8),
        .out_fire  (out_fire8),
        .out_beats (out_beats8),
        .out_err   (out_err8),
        .out_ovf   (out_ovf8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference: total of all beats, then wrap or clamp to the accumulator width.
    function automatic void model(input int bq[$], input int thr, input int w,
                                  output int sum, output int fire, output int ovf);
        longint total = 0;
        longint maxv  = (longint'(1) << w) - 1;
        foreach (bq[i]) total += bq[i];
`ifdef PERCEPTRON_ACC_SAT_EN
        if (total > maxv) begin
            sum = int'(maxv);
            ovf = 1;
        end else begin
            sum = int'(total);
            ovf = 0;
        end
`else
        sum = int'(total % (maxv + 1));
        ovf = 0;
`endif
        fire = (longint'(sum) >= (longint'(thr) & maxv)) ? 1 : 0;
    endfunction

    task automatic check_outputs(input int bq[$], input bit has_last, input int thr);
        int s, f, o;
        model(bq, thr, ACC_W, s, f, o);
        check("valid", out_valid, 1);
        check("in_ready_busy", in_ready, 0);
        check("sum", out_sum, s);
        check("fire", out_fire, f);
        check("beats", out_beats, bq.size());
        check("err", out_err, !has_last);
        check("ovf", out_ovf, o);
        model(bq, thr, ACC_W8, s, f, o);
        check("valid8", out_valid8, 1);
        check("sum8", out_sum8, s);
        check("fire8", out_fire8, f);
        check("beats8", out_beats8, bq.size());
        check("err8", out_err8, !has_last);
        check("ovf8", out_ovf8, o);
    endtask

    // Entered and left just after a negedge; each beat is accepted on the
    // posedge between two negedges.
    task automatic send_vector(input int bq[$], input bit has_last, input int thr,
                               input bit gaps);
        int waited;
        for (int i = 0; i < bq.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    in_valid  = 1'b0;
                    sum_in    = 7'($urandom);
                    in_last   = 1'($urandom);
                    threshold = ACC_W'($urandom);
                    @(negedge clk);
                end
            end
            in_valid  = 1'b1;
            sum_in    = 7'(bq[i]);
            in_last   = has_last && (i == bq.size() - 1);
            threshold = (i == 0) ? ACC_W'(thr) : ACC_W'($urandom);
            waited = 0;
            while (!in_ready && waited < BOUND) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= BOUND) check("accept_timeout", waited, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input int bq[$], input bit has_last, input int thr,
                                 input int hold);
        int waited = 0;
        while (!out_valid && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        check("latency", waited, 0);
        for (int h = 0; h <= hold; h++) begin
            check_outputs(bq, has_last, thr);
            if (h < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("valid_drop8", out_valid8, 0);
        check("ready_after", in_ready, 1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_valid8"}, out_valid8, 0);
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_sum"}, out_sum, 0);
        check({tag, "_fire"}, out_fire, 0);
        check({tag, "_beats"}, out_beats, 0);
        check({tag, "_err"}, out_err, 0);
        check({tag, "_ovf"}, out_ovf, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int thr;
        int len;
        bit last;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        sum_in    = '0;
        threshold = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_cleared("reset");

        // Single-beat vector.
        beats = '{84};
        send_vector(beats, 1'b1, 50, 1'b0);
        expect_result(beats, 1'b1, 50, 0);

        // Same data, threshold resampled per vector.
        beats = '{10, 20, 30, 40};
        send_vector(beats, 1'b1, 101, 1'b0);
        expect_result(beats, 1'b1, 101, 0);
        send_vector(beats, 1'b1, 100, 1'b0);
        expect_result(beats, 1'b1, 100, 0);

        // Backpressure with a beat waiting; threshold driven during DONE
        // must not affect the pending result.
        beats = '{25, 30};
        send_vector(beats, 1'b1, 40, 1'b0);
        in_valid  = 1'b1;
        sum_in    = 7'd9;
        in_last   = 1'b1;
        threshold = ACC_W'(9);
        expect_result(beats, 1'b1, 40, 5);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        beats = '{9};
        expect_result(beats, 1'b1, 9, 0);

        // Force termination at MAX_BEATS.
        beats.delete();
        for (int i = 0; i < MAX_BEATS; i++) beats.push_back(84);
        send_vector(beats, 1'b0, 2000, 1'b0);
        expect_result(beats, 1'b0, 2000, 1);

        // Reset mid-vector.
        beats = '{1, 2, 3};
        send_vector(beats, 1'b0, 3, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_cleared("mid_reset");
            @(negedge clk);
        end
        beats = '{7, 7};
        send_vector(beats, 1'b1, 14, 1'b0);
        expect_result(beats, 1'b1, 14, 0);

        // Reset while a result is pending.
        beats = '{5};
        send_vector(beats, 1'b1, 1, 1'b0);
        check("pend_valid", out_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_cleared("pend_reset");

        // Randomized vectors with input gaps and random output stalls.
        repeat (1000) begin
            len  = $urandom_range(1, 8);
            last = 1'b1;
            if ($urandom_range(0, 49) == 0) begin
                len  = MAX_BEATS;
                last = 1'b0;
            end
            beats.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) == 0) beats.push_back($urandom_range(85, 127));
                else beats.push_back($urandom_range(0, 84));
            end
            thr = $urandom_range(0, 450);
            send_vector(beats, last, thr, 1'b1);
            expect_result(beats, last, thr, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
